// File: rtl/cache_fill_fsm.sv
// Cache block fill sequencer.
// Issues one word read per cycle for every word of the missing block.
// Returned words are counted by data_valid, not by assumed latency, and
// each one is steered to its word offset in the cache data array. After
// the last word, one DONE cycle writes the tag and pulses fill_done.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for miss_detected; all outputs low, valids ignored
// FILL  | issuing reads (iss_cnt) and accepting returns (rx_cnt)
// DONE  | one cycle: tag write + fill_done, counters cleared
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_WIDTH-1:0]              miss_address,
  output logic                               fsm_busy,
  output logic                               mem_enable,
  output logic                               mem_wr,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  input  logic [15:0]                        memory_data,
  input  logic                               memory_data_valid,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_offset,
  output logic [15:0]                        fill_data,
  output logic                               write_tag_array,
  output logic                               fill_done
);

  localparam int WW  = $clog2(WORDS_PER_BLOCK);
  // byte-offset bits within a block (block is 2*WORDS_PER_BLOCK bytes)
  localparam int OFF = WW + 1;
  // counters hold 0..WORDS_PER_BLOCK inclusive
  localparam int CW  = WW + 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(WORDS_PER_BLOCK);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK =
    {{(ADDR_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_nxt;
  logic [CW-1:0]           iss_cnt_q, iss_cnt_nxt;
  logic [CW-1:0]           rx_cnt_q, rx_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   base_q, base_nxt;
  logic [ADDR_WIDTH-1:0]   issue_byte_off;
  logic                    issuing;
  logic                    accepting;

  // byte offset of the word being issued; base has the low OFF bits clear,
  // so the sum never carries out of the block
  assign issue_byte_off = {{(ADDR_WIDTH-OFF){1'b0}}, iss_cnt_q[WW-1:0], 1'b0};

  assign issuing   = (state_q == ST_FILL) && (iss_cnt_q < CNT_FULL);
  // a valid with no outstanding read (stale or spurious) is dropped
  assign accepting = (state_q == ST_FILL) && memory_data_valid &&
                     (rx_cnt_q < iss_cnt_q);

  // state, counters and captured block base
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      iss_cnt_q <= '0;
      rx_cnt_q  <= '0;
      base_q    <= '0;
    end else begin
      state_q   <= state_nxt;
      iss_cnt_q <= iss_cnt_nxt;
      rx_cnt_q  <= rx_cnt_nxt;
      base_q    <= base_nxt;
    end
  end

  // next-state and output decode
  always_comb begin
    state_nxt        = state_q;
    iss_cnt_nxt      = iss_cnt_q;
    rx_cnt_nxt       = rx_cnt_q;
    base_nxt         = base_q;
    fsm_busy         = 1'b0;
    mem_enable       = 1'b0;
    mem_wr           = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    data_word_offset = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (miss_detected) begin
          base_nxt    = miss_address & BLK_MASK;
          iss_cnt_nxt = '0;
          rx_cnt_nxt  = '0;
          state_nxt   = ST_FILL;
        end
      end

      ST_FILL: begin
        fsm_busy = 1'b1;
        if (issuing) begin
          mem_enable  = 1'b1;
          mem_addr    = base_q + issue_byte_off;
          iss_cnt_nxt = iss_cnt_q + 1'b1;
        end
        if (accepting) begin
          write_data_array = 1'b1;
          data_word_offset = rx_cnt_q[WW-1:0];
          fill_data        = memory_data;
          rx_cnt_nxt       = rx_cnt_q + 1'b1;
          if (rx_cnt_q == CNT_LAST) begin
            state_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        fill_done       = 1'b1;
        iss_cnt_nxt     = '0;
        rx_cnt_nxt      = '0;
        state_nxt       = ST_IDLE;
      end

      default: begin
        state_nxt   = ST_IDLE;
        iss_cnt_nxt = '0;
        rx_cnt_nxt  = '0;
      end
    endcase
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Requester side of the 4-cycle-read word memory. On a cache miss it issues one read per cycle for every word of the missing block. It counts the data_valid returns, steers each returned word into the cache data array at the correct word offset, then writes the tag and signals completion. It sits between the cache hit/miss logic and the memory4c instance.

Parameters:
ADDR_WIDTH, 16, byte-address width; must match the memory.
WORDS_PER_BLOCK, 8, 16-bit words per cache block (power of 2); block size is 2*WORDS_PER_BLOCK bytes.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
miss_detected  in  1  cache miss request; sampled only in IDLE.
miss_address  in  ADDR_WIDTH  byte address of the missing access.
fsm_busy  out  1  high while a fill is in progress (FILL or DONE).
mem_enable  out  1  memory enable.
mem_wr  out  1  memory write strobe; always 0 from this block.
mem_addr  out  ADDR_WIDTH  word-aligned read address (bit 0 always 0).
memory_data  in  16  memory read data.
memory_data_valid  in  1  memory read-data valid.
write_data_array  out  1  write strobe for one word of the cache data array.
data_word_offset  out  log2(WORDS_PER_BLOCK)  word index within the block for fill_data.
fill_data  out  16  word to write; equals memory_data.
write_tag_array  out  1  one-cycle tag/valid write strobe.
fill_done  out  1  one-cycle completion pulse, coincident with write_tag_array.

Behaviour:
- Reset (rst_n low, any time, including mid-fill):
  - state=IDLE, iss_cnt=0, rx_cnt=0, base=0.
  - All outputs 0.
  - Takes effect immediately, without waiting for a clock edge.
- Derived values:
  - OFF = log2(2*WORDS_PER_BLOCK).
  - base = miss_address with bits [OFF-1:0] cleared, captured on the IDLE->FILL edge.
- States: IDLE, FILL, DONE.
- IDLE:
  - fsm_busy=0.
  - miss_detected=1 at a rising edge -> capture base, go to FILL.
  - memory_data_valid is ignored.
- FILL:
  - fsm_busy=1.
  - Issue: while iss_cnt < WORDS_PER_BLOCK, mem_enable=1, mem_wr=0, mem_addr = base + 2*iss_cnt (mod 2^ADDR_WIDTH), and iss_cnt increments each cycle.
  - Once all words are issued, mem_enable=0 and mem_addr=0.
  - Accept: a return is accepted when memory_data_valid=1 and rx_cnt < iss_cnt. Valids with no outstanding read are ignored, which also discards stale returns left over from a reset mid-fill.
  - On accept, in the same cycle (combinational): write_data_array=1, data_word_offset=rx_cnt, fill_data=memory_data. rx_cnt increments at the edge.
  - When not accepting: write_data_array=0; data_word_offset and fill_data are 0.
  - Issue and accept may occur in the same cycle.
  - Accepting word WORDS_PER_BLOCK-1 -> DONE at the next edge.
  - The FSM counts valids; it does not assume a fixed memory latency.
- DONE (exactly one cycle):
  - write_tag_array=1, fill_done=1, fsm_busy=1.
  - Clear both counters, then go to IDLE.
  - A miss_detected here is not captured; it is sampled again in IDLE.
- miss_detected and miss_address changes during FILL/DONE are ignored.
- Nominal timeline with the 4-cycle memory and WORDS_PER_BLOCK=8:
  - Miss sampled at edge 0.
  - Issues in cycles 1-8.
  - Returns in cycles 5-12.
  - DONE in cycle 13.
  - IDLE in cycle 14.
  - Total 14 cycles from miss to IDLE.
- Counter widths: log2(WORDS_PER_BLOCK)+1 bits, so the value WORDS_PER_BLOCK is representable.

Test Plan:
- Basic fill: miss_address=0x1236 against the memory model -> mem_addr 0x1230,0x1232,...,0x123E in cycles 1-8; write_data_array in cycles 5-12 with offsets 0-7 and data = mem[0x918..0x91F]; fill_done/write_tag_array high in cycle 13 only; fsm_busy low in cycle 14.
- Wrap: miss_address=0xFFF4 -> addresses 0xFFF0..0xFFFE, no wrap into 0x0000; 8 writes; done.
- Back-to-back: miss_detected held high continuously -> second fill starts with first issue in cycle 15; no issue in DONE or cycle 14.
- Spurious valid: memory_data_valid pulsed in IDLE, and in FILL cycle 1 before any return -> no write_data_array; rx_cnt unchanged.
- Reset mid-fill: rst_n low in cycle 6 -> all outputs 0 immediately; after release, stale valids are ignored; a new miss completes with 8 correct writes.
- Stretched latency: memory model delaying returns by 6 cycles with gaps -> still exactly 8 writes in order, offsets 0-7, then fill_done.
